// File: rtl/mem_port_arbiter.sv
// Purpose : round-robin share of one burst memory port between m0 (I-cache) and m1 (D-cache).
// Latency : 1 arbitration cycle, then the memory's own timing is passed straight through.
// Backpres: the granted master sees mem_waitrequest; the other master is held at waitrequest=1.
//
// Ports:
//   clock / reset                        system clock, synchronous active-high reset
//   mN_addr/burst_len/rd/wr/wr_data      master N burst request (N = 0, 1)
//   mN_rd_data/rd_valid/waitrequest      master N response; rd_data is shared
//   mem_*                                memory side of the shared port
//   stat_grants0/1                       completed transactions per master
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURSTLEN_WIDTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    input  logic [BURSTLEN_WIDTH-1:0] m0_burst_len,
    input  logic                      m0_rd,
    input  logic                      m0_wr,
    input  logic [DATA_WIDTH-1:0]     m0_wr_data,
    output logic [DATA_WIDTH-1:0]     m0_rd_data,
    output logic                      m0_rd_valid,
    output logic                      m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic [BURSTLEN_WIDTH-1:0] m1_burst_len,
    input  logic                      m1_rd,
    input  logic                      m1_wr,
    input  logic [DATA_WIDTH-1:0]     m1_wr_data,
    output logic [DATA_WIDTH-1:0]     m1_rd_data,
    output logic                      m1_rd_valid,
    output logic                      m1_waitrequest,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [BURSTLEN_WIDTH-1:0] mem_burst_len,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [DATA_WIDTH-1:0]     mem_wr_data,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    input  logic                      mem_rd_valid,
    input  logic                      mem_waitrequest,
    output logic [31:0]               stat_grants0,
    output logic [31:0]               stat_grants1
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_WAIT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      prio_q, prio_d;
    logic                      cmd_done_q, cmd_done_d;
    logic [BURSTLEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [BURSTLEN_WIDTH-1:0] len_q, len_d;
    logic [31:0]               stat0_q, stat0_d;
    logic [31:0]               stat1_q, stat1_d;

    // Signals of whichever master currently holds the grant.
    logic                      g_rd;
    logic                      g_wr;
    logic                      g_wait;
    logic                      req0;
    logic                      req1;
    logic                      arb_gnt;
    logic                      last_beat;

    assign g_rd      = grant_q ? m1_rd : m0_rd;
    assign g_wr      = grant_q ? m1_wr : m0_wr;
    assign req0      = m0_rd | m0_wr;
    assign req1      = m1_rd | m1_wr;
    // Tie goes to prio; otherwise the sole requester (m0 if nobody, unused then).
    assign arb_gnt   = (req0 && req1) ? prio_q : req1;
    assign last_beat = (cnt_q == len_q);

    assign m0_rd_data    = mem_rd_data;
    assign m1_rd_data    = mem_rd_data;
    assign stat_grants0  = stat0_q;
    assign stat_grants1  = stat1_q;
    assign mem_addr      = grant_q ? m1_addr      : m0_addr;
    assign mem_burst_len = grant_q ? m1_burst_len : m0_burst_len;
    assign mem_wr_data   = grant_q ? m1_wr_data   : m0_wr_data;

    // Port-side outputs. mem_rd/mem_wr depend only on state and master
    // inputs, never on mem_waitrequest.
    always_comb begin
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        g_wait      = 1'b1;
        m0_rd_valid = 1'b0;
        m1_rd_valid = 1'b0;
        case (state_q)
            WR_BURST: begin
                mem_wr = g_wr;
                g_wait = mem_waitrequest;
            end
            RD_WAIT: begin
                // Once the command is taken the master is held off so it
                // cannot issue a second command into this burst.
                mem_rd      = g_rd & ~cmd_done_q;
                g_wait      = cmd_done_q | mem_waitrequest;
                m0_rd_valid = mem_rd_valid & ~grant_q;
                m1_rd_valid = mem_rd_valid &  grant_q;
            end
            default: ;
        endcase
        m0_waitrequest = grant_q ? 1'b1 : g_wait;
        m1_waitrequest = grant_q ? g_wait : 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_d     = prio_q;
        cmd_done_d = cmd_done_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        stat0_d    = stat0_q;
        stat1_d    = stat1_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d    = arb_gnt;
                    len_d      = arb_gnt ? m1_burst_len : m0_burst_len;
                    cnt_d      = '0;
                    cmd_done_d = 1'b0;
                    // rd+wr together from one master is resolved as a write.
                    state_d    = (arb_gnt ? m1_wr : m0_wr) ? WR_BURST : RD_WAIT;
                end
            end
            WR_BURST: begin
                if (mem_wr && !mem_waitrequest) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        prio_d  = ~grant_q;
                        cnt_d   = '0;
                        if (grant_q) stat1_d = stat1_q + 32'd1;
                        else         stat0_d = stat0_q + 32'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_rd && !mem_waitrequest) cmd_done_d = 1'b1;
                if (mem_rd_valid) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        prio_d  = ~grant_q;
                        cnt_d   = '0;
                        if (grant_q) stat1_d = stat1_q + 32'd1;
                        else         stat0_d = stat0_q + 32'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            prio_q     <= 1'b0;
            cmd_done_q <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            stat0_q    <= '0;
            stat1_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_q     <= prio_d;
            cmd_done_q <= cmd_done_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            stat0_q    <= stat0_d;
            stat1_q    <= stat1_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed scoreboard bench for mem_port_arbiter with a burst memory model.
// Latency : memory takes 1 waitrequest cycle per command, read beats start the cycle after acceptance.
// Backpres: masters hold requests/beats until their waitrequest drops; memory can stall mid write burst.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] m0_addr, m1_addr;
    logic [1:0]  m0_burst_len, m1_burst_len;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0] m0_wr_data, m1_wr_data;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        m0_rd_valid, m1_rd_valid;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] mem_addr;
    logic [1:0]  mem_burst_len;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_waitrequest;
    logic [31:0] stat_grants0, stat_grants1;

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURSTLEN_WIDTH(2)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_addr(m0_addr), .m0_burst_len(m0_burst_len), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
        .m0_waitrequest(m0_waitrequest),
        .m1_addr(m1_addr), .m1_burst_len(m1_burst_len), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
        .m1_waitrequest(m1_waitrequest),
        .mem_addr(mem_addr), .mem_burst_len(mem_burst_len), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .mem_waitrequest(mem_waitrequest),
        .stat_grants0(stat_grants0), .stat_grants1(stat_grants1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_rd0   = 0;
    int n_rd1   = 0;
    int n_wr    = 0;

    // Scoreboard queues: command start addresses in grant order, read data per master, write beats.
    logic [31:0] exp_cmd[$];
    logic [31:0] exp_rd0[$];
    logic [31:0] exp_rd1[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    // Memory model state; mem[i] = i is the sequential image (word 0x40 holds 0x40).
    logic [31:0] mem [0:4095];
    int cmd_wait   = 1;
    int stall_left = 1;
    int stall_mid  = 0;
    int stall_at   = 2;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Memory model: observe the cycle at negedge, apply its effects just after the next posedge.
    initial begin : mem_model
        logic        st, wa, ra;
        logic [31:0] a, d;
        logic [1:0]  l;
        int wr_beat, wr_len, wr_base, rd_left, rd_ptr;
        wr_beat = 0; wr_len = 0; wr_base = 0; rd_left = 0; rd_ptr = 0;
        for (int i = 0; i < 4096; i++) mem[i] = i;
        mem_rd_valid    = 1'b0;
        mem_rd_data     = 32'hDEAD_BEEF;
        mem_waitrequest = 1'b1;
        forever begin
            @(negedge clock);
            st = (mem_rd || mem_wr) && mem_waitrequest;
            wa = mem_wr && !mem_waitrequest;
            ra = mem_rd && !mem_waitrequest;
            a  = mem_addr;
            d  = mem_wr_data;
            l  = mem_burst_len;
            @(posedge clock);
            #1;
            if (st && stall_left > 0) stall_left--;
            if (wa) begin
                if (wr_beat == 0) begin
                    wr_base = int'(a[13:2]);
                    wr_len  = int'(l);
                end
                mem[wr_base + wr_beat] = d;
                if (wr_beat == wr_len) begin
                    wr_beat    = 0;
                    stall_left = cmd_wait;
                end else begin
                    wr_beat++;
                    if (wr_beat == stall_at && stall_mid > 0) begin
                        stall_left = stall_mid;
                        stall_mid  = 0;
                    end
                end
            end
            if (ra) begin
                rd_left = int'(l) + 1;
                rd_ptr  = int'(a[13:2]);
            end
            if (rd_left > 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[rd_ptr];
                rd_ptr++;
                rd_left--;
                if (rd_left == 0) stall_left = cmd_wait;
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data  = 32'hDEAD_BEEF;
            end
            mem_waitrequest = (stall_left > 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or command.
    initial begin : monitor
        int          widx;
        int          wlen;
        logic [31:0] wbase;
        widx = 0; wlen = 0; wbase = 0;
        forever begin
            @(negedge clock);
            if (m0_rd && m0_wr) flag_fail("m0_rd_and_wr");
            if (m1_rd && m1_wr) flag_fail("m1_rd_and_wr");
            if (m0_rd_valid) begin
                n_rd0++;
                if (exp_rd0.size() == 0) flag_fail("rd0_unexpected_beat");
                else check("rd0_data", m0_rd_data, exp_rd0.pop_front());
            end
            if (m1_rd_valid) begin
                n_rd1++;
                if (exp_rd1.size() == 0) flag_fail("rd1_unexpected_beat");
                else check("rd1_data", m1_rd_data, exp_rd1.pop_front());
            end
            if (mem_rd && !mem_waitrequest) begin
                if (exp_cmd.size() == 0) flag_fail("rd_cmd_unexpected");
                else check("rd_cmd_addr", mem_addr, exp_cmd.pop_front());
            end
            if (mem_wr && !mem_waitrequest) begin
                if (widx == 0) begin
                    wbase = mem_addr;
                    wlen  = int'(mem_burst_len);
                    if (exp_cmd.size() == 0) flag_fail("wr_cmd_unexpected");
                    else check("wr_cmd_addr", mem_addr, exp_cmd.pop_front());
                end
                n_wr++;
                if (exp_wa.size() == 0) flag_fail("wr_beat_unexpected");
                else begin
                    check("wr_beat_addr", wbase + 32'(4 * widx), exp_wa.pop_front());
                    check("wr_beat_data", mem_wr_data, exp_wd.pop_front());
                end
                widx = (widx == wlen) ? 0 : widx + 1;
            end
        end
    end

    task automatic rd_req(input int m, input logic [31:0] a, input logic [1:0] l);
        bit ok = 0;
        if (m == 0) begin m0_addr = a; m0_burst_len = l; m0_rd = 1'b1; end
        else        begin m1_addr = a; m1_burst_len = l; m1_rd = 1'b1; end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            ok = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
        end
        if (!ok) flag_fail("rd_cmd_timeout");
        @(posedge clock);
        #1;
        if (m == 0) m0_rd = 1'b0; else m1_rd = 1'b0;
    endtask

    task automatic m1_write(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d0);
        bit ok;
        m1_addr = a; m1_burst_len = l; m1_wr = 1'b1;
        for (int b = 0; b <= int'(l); b++) begin
            m1_wr_data = d0 + 32'(b);
            ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clock);
                ok = !m1_waitrequest;
            end
            if (!ok) flag_fail("wr_beat_timeout");
            @(posedge clock);
            #1;
        end
        m1_wr = 1'b0;
    endtask

    task automatic push_read(input int m, input logic [31:0] a, input int beats);
        exp_cmd.push_back(a);
        for (int k = 0; k < beats; k++)
            if (m == 0) exp_rd0.push_back(32'(a[13:2]) + 32'(k));
            else        exp_rd1.push_back(32'(a[13:2]) + 32'(k));
    endtask

    task automatic push_write(input logic [31:0] a, input int beats, input logic [31:0] d0);
        exp_cmd.push_back(a);
        for (int k = 0; k < beats; k++) begin
            exp_wa.push_back(a + 32'(4 * k));
            exp_wd.push_back(d0 + 32'(k));
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clock);
            #1;
            done = (exp_cmd.size() == 0) && (exp_rd0.size() == 0) && (exp_rd1.size() == 0)
                   && (exp_wa.size() == 0);
        end
        if (!done) flag_fail(name);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base, viol, e1, e2, t0;
        bit seen;
        m0_addr = 0; m0_burst_len = 0; m0_rd = 0; m0_wr = 0; m0_wr_data = 0;
        m1_addr = 0; m1_burst_len = 0; m1_rd = 0; m1_wr = 0; m1_wr_data = 0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_reset();

        // Reset state
        @(negedge clock);
        check("rst_m0_waitrequest", m0_waitrequest, 1);
        check("rst_m1_waitrequest", m1_waitrequest, 1);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_m0_rd_valid", m0_rd_valid, 0);
        check("rst_stat0", stat_grants0, 0);
        check("rst_stat1", stat_grants1, 0);
        @(posedge clock);
        #1;

        // m0 alone reads 0x100, 4 beats
        push_read(0, 32'h100, 4);
        rd_req(0, 32'h100, 2'd3);
        wait_drain("t1_drain");
        check("t1_rd0_beats", n_rd0, 4);
        check("t1_rd1_beats", n_rd1, 0);
        check("t1_stat0", stat_grants0, 1);

        // Simultaneous requests after reset: m0 read first, then m1 write
        do_reset();
        push_read(0, 32'h0, 4);
        push_write(32'h2000, 4, 32'hA0);
        base = n_rd0;
        viol = 0;
        fork
            rd_req(0, 32'h0, 2'd3);
            m1_write(32'h2000, 2'd3, 32'hA0);
            begin
                for (int i = 0; i < 300 && n_rd0 < base + 4; i++) begin
                    @(negedge clock);
                    if (!m1_waitrequest) viol++;
                end
            end
        join
        wait_drain("t2_drain");
        check("t2_m1_wait_during_m0", viol, 0);
        check("t2_stat0", stat_grants0, 1);
        check("t2_stat1", stat_grants1, 1);
        check("t2_prio", dut.prio_q, 0);

        // m1 reads back its own write; routed to m1 only
        push_read(1, 32'h2000, 2);
        exp_rd1.delete();
        exp_rd1.push_back(32'hA0);
        exp_rd1.push_back(32'hA1);
        rd_req(1, 32'h2000, 2'd1);
        wait_drain("t2b_drain");
        check("t2b_rd1_beats", n_rd1, 2);
        check("t2b_stat1", stat_grants1, 2);

        // m1 two writes back-to-back while m0 waits: order m1, m0, m1
        push_write(32'h3000, 4, 32'hB0);
        push_read(0, 32'h200, 4);
        push_write(32'h3010, 4, 32'hC0);
        fork
            begin
                m1_write(32'h3000, 2'd3, 32'hB0);
                m1_write(32'h3010, 2'd3, 32'hC0);
            end
            begin
                @(posedge clock);
                #1;
                rd_req(0, 32'h200, 2'd3);
            end
        join
        wait_drain("t3_drain");
        check("t3_stat0", stat_grants0, 2);
        check("t3_stat1", stat_grants1, 4);

        // Mid-burst stall of 5 cycles costs exactly 5 cycles and 4 beats
        push_write(32'h4000, 4, 32'hD0);
        t0 = cyc;
        m1_write(32'h4000, 2'd3, 32'hD0);
        e1 = cyc - t0;
        wait_drain("t4a_drain");
        push_write(32'h4010, 4, 32'hE0);
        base = n_wr;
        stall_mid = 5;
        t0 = cyc;
        m1_write(32'h4010, 2'd3, 32'hE0);
        e2 = cyc - t0;
        wait_drain("t4b_drain");
        check("t4_stall_extra_cycles", e2 - e1, 5);
        check("t4_beats_written", n_wr - base, 4);
        check("t4_stat1", stat_grants1, 6);

        // Reset at the 2nd read beat: only 2 beats forwarded
        exp_cmd.push_back(32'h300);
        exp_rd0.push_back(32'hC0);
        exp_rd0.push_back(32'hC1);
        base = n_rd0;
        fork
            rd_req(0, 32'h300, 2'd3);
            begin
                seen = 0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clock);
                    seen = (n_rd0 > base);
                end
                if (!seen) flag_fail("t5_first_beat_timeout");
                @(posedge clock);
                #1;
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
                @(negedge clock);
                check("t5_m0_rd_valid", m0_rd_valid, 0);
                check("t5_m0_waitrequest", m0_waitrequest, 1);
                check("t5_m1_waitrequest", m1_waitrequest, 1);
                check("t5_mem_rd", mem_rd, 0);
                check("t5_mem_wr", mem_wr, 0);
            end
        join
        wait_drain("t5_drain");
        check("t5_rd0_beats", n_rd0 - base, 2);
        check("t5_stat0", stat_grants0, 0);
        check("t5_stat1", stat_grants1, 0);

        // Stalled write landed intact; stats restart from zero
        exp_cmd.push_back(32'h4010);
        for (int k = 0; k < 4; k++) exp_rd0.push_back(32'hE0 + 32'(k));
        rd_req(0, 32'h4010, 2'd3);
        wait_drain("t6_drain");
        check("t6_stat0", stat_grants0, 1);
        check("t6_stat_sum", stat_grants0 + stat_grants1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
